md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
Multiply/divide unit for the 5-stage MIPS pipeline. It sits in the E stage beside the ALU. It executes mult/multu/div/divu over a fixed multi-cycle latency and holds the architectural HI/LO registers. It services mthi/mtlo writes and drives busy to the hazard unit, which stalls D whenever an md-class instruction is in D while (start || busy).

Parameters:
MUL_CYCLES, 5, cycles busy is high after an accepted mult/multu (legal range 1..15)
DIV_CYCLES, 10, cycles busy is high after an accepted div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle launch pulse from E-stage decode
md_op  input  2  00 multu, 01 mult, 10 divu, 11 div; sampled only when start=1
A  input  32  forwarded rs operand (E stage)
B  input  32  forwarded rt operand (E stage)
hi_we  input  1  mthi: write A into HI
lo_we  input  1  mtlo: write A into LO
busy  output  1  registered; operation in flight
HI  output  32  architectural HI register (mfhi source)
LO  output  32  architectural LO register (mflo source)

Behaviour:
- Reset (asynchronous, any time): busy=0, HI=0, LO=0, count=0, pending result registers=0. An in-flight operation is discarded and never commits.
- Idle state (busy=0):
  - start=1: at that edge, latch the computed result into pending_hi/pending_lo, load count with MUL_CYCLES or DIV_CYCLES, and set busy=1.
  - The result is computed combinationally from A/B/md_op in the start cycle. The operands do not need to be held afterwards.
- Busy state: count decrements each edge.
  - At the edge where count==1: HI<=pending_hi, LO<=pending_lo, busy<=0.
  - busy is therefore high for exactly N cycles after the start cycle. New HI/LO are visible in the first cycle in which busy=0.
- start while busy=1: ignored. The hazard unit guarantees this does not occur; the bench checks that pending state is unchanged.
- hi_we/lo_we while busy=1: ignored.
- hi_we/lo_we while idle: write at that edge, visible next cycle.
- Simultaneous start and hi_we/lo_we while idle: start takes priority and the writes are dropped. This cannot come from legal decode.
- The hazard unit must not let mfhi/mflo leave D while (start || busy). This block does not forward pending results.
- Arithmetic:
  - multu: {HI,LO} = zero-extended A*B, 64-bit.
  - mult: {HI,LO} = signed A*B, 64-bit two's complement.
  - divu: LO = A/B, HI = A%B, unsigned.
  - div: quotient truncates toward zero, and the remainder takes the sign of the dividend (A).
- Divide boundary cases:
  - B==0 (div or divu): LO=32'hFFFFFFFF, HI=A.
  - div 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- The count width is 4 bits. Parameters outside 1..15 are illegal and are not checked.

Test Plan:
- Reset, then mult with A=32'hFFFFFFFD (-3), B=5 -> busy high for 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; busy=0 in that same cycle.
- multu with A=B=32'hFFFFFFFF -> after 5 busy cycles HI=32'hFFFFFFFE, LO=32'h00000001.
- div with A=32'hFFFFFFF9 (-7), B=2 -> busy for 10 cycles; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. Also divu with A=7, B=0 -> LO=32'hFFFFFFFF, HI=7.
- Idle lo_we with A=32'h12345678, next cycle hi_we with A=32'hDEADBEEF -> LO=32'h12345678 and HI=32'hDEADBEEF, each one cycle after its write. Then start a mult and assert hi_we during busy -> HI shows only the mult result at completion.
- Start a div (A=100, B=7); assert start again with multu at cycle 3 of busy -> ignored. Completion still occurs at cycle 10 with LO=14, HI=2.
- Start a mult; assert reset asynchronously (mid-cycle) at busy cycle 2 -> busy, HI and LO go to 0 immediately. After reset release, no commit ever occurs.

Source files
------------

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage launch/operand signals and HI/LO/busy results of the multiply/divide unit
interface md_unit_if;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output start, md_op, A, B, hi_we, lo_we, input busy, HI, LO);
    modport slave (input start, md_op, A, B, hi_we, lo_we, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit: fixed-latency mult/div unit holding HI/LO; result computed at launch, committed when the countdown expires
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic   clk,
    input logic   reset,
    md_unit_if.slave md
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic [3:0]  count;
    logic [31:0] pending_hi, pending_lo, hi, lo, res_hi, res_lo;
    logic [63:0] prod_u, prod_s;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, sq, sr;
    logic        sa, sb, b_zero;
    assign prod_u = {32'b0, md.A} * {32'b0, md.B};
    assign prod_s = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
    assign b_zero = md.B == 32'b0;
    assign sa     = md.A[31];
    assign sb     = md.B[31];
    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally
    assign abs_a  = sa ? -md.A : md.A;
    assign abs_b  = sb ? -md.B : md.B;
    assign q_mag  = b_zero ? 32'b0 : abs_a / abs_b;
    assign r_mag  = b_zero ? 32'b0 : abs_a % abs_b;
    assign sq     = (sa ^ sb) ? -q_mag : q_mag;
    assign sr     = sa ? -r_mag : r_mag;
    always_comb begin
        res_hi = 32'b0;
        res_lo = 32'b0;
        case (md.md_op)
            2'b00: {res_hi, res_lo} = prod_u;
            2'b01: {res_hi, res_lo} = prod_s;
            2'b10: {res_hi, res_lo} = b_zero ? {md.A, 32'hFFFFFFFF} : {md.A % md.B, md.A / md.B};
            default: {res_hi, res_lo} = b_zero ? {md.A, 32'hFFFFFFFF} : {sr, sq};
        endcase
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && md.start)
            state_n = BUSY;
        else if (state == BUSY && count == 4'd1)
            state_n = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            pending_hi <= 32'b0;
            pending_lo <= 32'b0;
            hi         <= 32'b0;
            lo         <= 32'b0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                if (md.start) begin
                    pending_hi <= res_hi;
                    pending_lo <= res_lo;
                    count      <= md.md_op[1] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                end else begin
                    if (md.hi_we) hi <= md.A;
                    if (md.lo_we) lo <= md.A;
                end
            end else begin
                count <= count - 4'd1;
                if (count == 4'd1) begin
                    hi <= pending_hi;
                    lo <= pending_lo;
                end
            end
        end
    end
    assign md.busy = state == BUSY;
    assign md.HI   = hi;
    assign md.LO   = lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors for md_unit with hand-computed HI/LO and busy-length expectations
module tb_md_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int n, m;
    md_unit_if ifc ();
    md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(ifc));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        ifc.start = 1'b1;
        ifc.md_op = op;
        ifc.A = a;
        ifc.B = b;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (ifc.busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
    endtask
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int cyc, input logic [31:0] ehi, input logic [31:0] elo);
        int c;
        launch(op, a, b);
        wait_idle(c);
        chk({tag, "_cycles"}, 32'(c), 32'(cyc));
        chk({tag, "_hi"}, ifc.HI, ehi);
        chk({tag, "_lo"}, ifc.LO, elo);
    endtask
    initial begin
        {ifc.start, ifc.md_op, ifc.A, ifc.B, ifc.hi_we, ifc.lo_we} = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_hi", ifc.HI, 32'd0);
        chk("rst_lo", ifc.LO, 32'd0);
        run("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        run("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu_zero", 2'b10, 32'd7, 32'd0, 10, 32'd7, 32'hFFFFFFFF);
        run("div_zero", 2'b11, 32'hFFFFFFF9, 32'd0, 10, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        run("divu_big", 2'b10, 32'hFFFFFFF9, 32'd2, 10, 32'd1, 32'h7FFFFFFC);
        // idle mtlo then mthi
        ifc.lo_we = 1'b1;
        ifc.A = 32'h12345678;
        @(negedge clk);
        ifc.lo_we = 1'b0;
        chk("mtlo", ifc.LO, 32'h12345678);
        ifc.hi_we = 1'b1;
        ifc.A = 32'hDEADBEEF;
        @(negedge clk);
        ifc.hi_we = 1'b0;
        chk("mthi", ifc.HI, 32'hDEADBEEF);
        chk("mthi_lo_kept", ifc.LO, 32'h12345678);
        // mthi during busy is dropped
        launch(2'b01, 32'd3, 32'd4);
        ifc.hi_we = 1'b1;
        ifc.lo_we = 1'b1;
        ifc.A = 32'hFFFF0000;
        repeat (2) @(negedge clk);
        chk("we_busy_hi", ifc.HI, 32'hDEADBEEF);
        ifc.hi_we = 1'b0;
        ifc.lo_we = 1'b0;
        wait_idle(n);
        chk("we_busy_cycles", 32'(n + 2), 32'd5);
        chk("we_busy_hi_end", ifc.HI, 32'd0);
        chk("we_busy_lo_end", ifc.LO, 32'd12);
        // start while busy is ignored
        launch(2'b11, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(m);
        chk("restart_cycles", 32'(m + 3), 32'd10);
        chk("restart_hi", ifc.HI, 32'd2);
        chk("restart_lo", ifc.LO, 32'd14);
        // simultaneous start and mthi when idle: start wins
        ifc.hi_we = 1'b1;
        launch(2'b00, 32'd6, 32'd7);
        ifc.hi_we = 1'b0;
        wait_idle(n);
        chk("prio_hi", ifc.HI, 32'd0);
        chk("prio_lo", ifc.LO, 32'd42);
        // async reset mid-operation
        launch(2'b01, 32'd2, 32'd3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(ifc.busy), 32'd0);
        chk("arst_hi", ifc.HI, 32'd0);
        chk("arst_lo", ifc.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("arst_busy_after", 32'(ifc.busy), 32'd0);
        chk("arst_no_commit_hi", ifc.HI, 32'd0);
        chk("arst_no_commit_lo", ifc.LO, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
